hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Register-dependency scoreboard in the decode (D) stage that produces the 2-bit stall_D request consumed by the pipeline stall controller.
- Tracks, per architectural register, the cycles remaining until an in-flight producer's result is forwardable.
- For the instruction currently in D, reports how many bubble cycles must be inserted.
- Observes the controller's de_en/de_flush/em_en outputs to know when instructions actually issue and when the pipeline is frozen.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never hazardous.
REG_AW, 5, register index width.
CNT_W, 2, per-register countdown width; also the stall_D width.
LOAD_LAT, 1, bubble cycles needed by a dependent of a load (load-use).
MUL_LAT, 2, bubble cycles needed by a dependent of a multiply; must be ≤ 2^CNT_W-1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
D_valid  in  1  D-stage slot holds a real instruction.
D_rs1  in  REG_AW  source register 1.
D_rs1_used  in  1  rs1 is read.
D_rs2  in  REG_AW  source register 2.
D_rs2_used  in  1  rs2 is read.
D_rd  in  REG_AW  destination register.
D_RegWrite  in  1  instruction writes rd.
D_lat_class  in  2  0=ALU, 1=load, 2=mul, 3=reserved (treated as ALU).
de_en  in  1  D→E register enable from the stall controller.
de_flush  in  1  D→E register flush from the stall controller.
em_en  in  1  E→M enable; 0 = pipeline frozen by a memory stall.
squash_E  in  1  branch redirect kills the instruction currently in E.
stall_D  out  CNT_W  bubble cycles required before the D instruction may issue.
sb_busy  out  1  any counter nonzero.
sb_hazard  out  1  stall_D != 0.

Behaviour:
- State: cnt[NUM_REGS] of CNT_W bits each; e_valid, e_rd, e_wr track the instruction presently in E.
- Reset (synchronous, rst=1 at posedge): all cnt=0, e_valid=0, e_rd=0, e_wr=0. Outputs are derived from state, so stall_D=0, sb_busy=0, sb_hazard=0 in the cycle after reset. Reset mid-operation discards all pending hazards immediately.
- stall_D is combinational from the registered cnt and the current D inputs:
  - s1 = cnt[D_rs1] if D_valid & D_rs1_used & D_rs1!=0, else 0; s2 likewise for rs2.
  - stall_D = max(s1, s2). Zero-cycle input-to-output path; no decrement lookahead.
- Issue condition: issue = D_valid & de_en & !de_flush.
- Latency load value L: class 1 → LOAD_LAT, class 2 → MUL_LAT, class 0/3 → 0. Values saturate to 2^CNT_W-1.
- Per-register update each posedge, highest priority first:
  1. rst → 0.
  2. issue & D_RegWrite & D_rd==r & r!=0 → cnt[r]=L.
  3. squash_E & e_valid & e_wr & e_rd==r → cnt[r]=0.
  4. em_en=1 & cnt[r]!=0 → cnt[r]-1.
  5. Otherwise hold.
- Freeze: while em_en=0, no counter decrements, so stall_D stays stable across a memory stall. This is required because the controller samples stall_D after the memory stall resolves.
- E tracking:
  - issue → e_valid=1, e_rd=D_rd, e_wr=D_RegWrite.
  - else if de_en=1 or de_flush=1 → e_valid=0 (bubble enters E).
  - else hold.
  - squash_E also clears e_valid, unless an issue occurs in the same cycle (issue wins).
- Simultaneous events:
  - Issue and squash targeting the same rd: issue's L wins.
  - Issue to rd=0: ignored.
  - A source equal to a same-cycle issuing rd sees the old count; D cannot read its own result.
- Dependent already counted: while the controller holds D (de_en=0, em_en=1), counters decrement each cycle, so when D is released stall_D equals 0 for a correctly sized stall.
- Counters never wrap: decrement stops at 0, and L is saturated.
- sb_busy = OR of all cnt != 0. sb_hazard = |stall_D.

Decomposition:
Shared pipeline package holds:
- lat_class encoding constants: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2.
- REG_AW and CNT_W.

One natural sub-module, sb_counter: a single saturating CNT_W countdown with load/clear/decrement priority, instantiated NUM_REGS-1 times via generate. Register 0 is tied to zero.

Test Plan:
1. Load x5 issues (class 1, em_en=1); next cycle D reads rs1=x5 → stall_D=1. One cycle with de_en=0 → stall_D=0.
2. Mul x7 issues (class 2); next D reads rs2=x7 → stall_D=2. With em_en=0 for 3 cycles, stall_D stays 2. After em_en returns to 1, it reads 1, then 0.
3. ALU x3 issues, then dependent on x3 → stall_D=0. Writes and reads of x0 with a load → stall_D=0.
4. Load x9 issues; next cycle squash_E=1 with no issue → cnt[9]=0. Dependent on x9 → stall_D=0.
5. rs1=x4 pending 1 and rs2=x6 pending 2 → stall_D=2 (max). rs1_used=0 with rs2 not pending → stall_D=0.
6. rst asserted while cnt[5]=2 → next cycle stall_D=0 and sb_busy=0. An issue in the same cycle as rst is discarded.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode-stage types for the register hazard scoreboard.
// Latency-class encodings, widths and the latency saturation helper.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  localparam logic [1:0] LAT_ALU  = 2'd0;
  localparam logic [1:0] LAT_LOAD = 2'd1;
  localparam logic [1:0] LAT_MUL  = 2'd2;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     wr;
  } e_slot_t;

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  function automatic cnt_t sat_lat(input int unsigned lat);
    if (lat > CNT_MAX) sat_lat = cnt_t'(CNT_MAX);
    else               sat_lat = cnt_t'(lat);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the D stage / stall controller
// and the hazard scoreboard.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic       D_valid;
  reg_idx_t   D_rs1;
  logic       D_rs1_used;
  reg_idx_t   D_rs2;
  logic       D_rs2_used;
  reg_idx_t   D_rd;
  logic       D_RegWrite;
  logic [1:0] D_lat_class;
  logic       de_en;
  logic       de_flush;
  logic       em_en;
  logic       squash_E;
  cnt_t       stall_D;
  logic       sb_busy;
  logic       sb_hazard;

  modport master (
    output D_valid, D_rs1, D_rs1_used,
    output D_rs2, D_rs2_used, D_rd,
    output D_RegWrite, D_lat_class,
    output de_en, de_flush, em_en, squash_E,
    input  stall_D, sb_busy, sb_hazard
  );

  modport slave (
    input  D_valid, D_rs1, D_rs1_used,
    input  D_rs2, D_rs2_used, D_rd,
    input  D_RegWrite, D_lat_class,
    input  de_en, de_flush, em_en, squash_E,
    output stall_D, sb_busy, sb_hazard
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// One register's countdown: load beats clear beats decrement,
// and the count never wraps below zero.
module sb_counter
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  input  logic clear,
  input  logic dec,
  output cnt_t cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (clear)
      cnt <= '0;
    else if (dec && cnt != '0)
      cnt <= cnt - cnt_t'(1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard producing the stall_D
// bubble request for the pipeline stall controller.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);

  cnt_t    cnt [NUM_REGS];
  cnt_t    lat;
  cnt_t    s1;
  cnt_t    s2;
  cnt_t    stall;
  logic    issue;
  logic    busy;
  e_slot_t e_q;

  assign issue = sb.D_valid & sb.de_en & ~sb.de_flush;

  always_comb begin
    lat = '0;
    case (sb.D_lat_class)
      LAT_LOAD: lat = sat_lat(LOAD_LAT);
      LAT_MUL:  lat = sat_lat(MUL_LAT);
      default:  lat = '0;
    endcase
  end

  // x0 is never a hazard, so it has no counter.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic ld;
    logic clr;

    assign ld  = issue & sb.D_RegWrite
               & (sb.D_rd == REG_AW'(r));
    assign clr = sb.squash_E & e_q.valid & e_q.wr
               & (e_q.rd == REG_AW'(r));

    sb_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (lat),
      .clear    (clr),
      .dec      (sb.em_en),
      .cnt      (cnt[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      e_q <= '0;
    else if (issue)
      e_q <= '{valid: 1'b1, rd: sb.D_rd, wr: sb.D_RegWrite};
    else if (sb.de_en || sb.de_flush || sb.squash_E)
      e_q.valid <= 1'b0;
  end

  // Sources read the registered counts: no same-cycle bypass.
  always_comb begin
    s1 = '0;
    s2 = '0;
    if (sb.D_valid && sb.D_rs1_used && sb.D_rs1 != '0)
      s1 = cnt[sb.D_rs1];
    if (sb.D_valid && sb.D_rs2_used && sb.D_rs2 != '0)
      s2 = cnt[sb.D_rs2];
    stall = (s1 > s2) ? s1 : s2;
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++)
      busy = busy | (cnt[r] != '0);
  end

  assign sb.stall_D   = stall;
  assign sb.sb_busy   = busy;
  assign sb.sb_hazard = |stall;

endmodule
